mem_wb_stage: RTL and testbench

Memory/writeback pipeline stage of the processor. It registers one instruction's writeback candidates and holds it while a load's data is outstanding. It presents those candidates as the four data inputs and the select of the writeback 4:1 multiplexer, and emits a single-cycle register-file write strobe. A cycle-count watchdog bounds how long a load may wait for memory.

---
 rtl/mem_wb_pkg.sv | 16 +
 rtl/mem_wb_stage_if.sv | 37 +++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/mem_wb_stage.sv | 94 +++++++++
 tb/tb_mem_wb_stage.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_pkg.sv
// Shared writeback-source codes and stage state encoding for the memory/writeback stage.
// The decoder drives IN_WB_SEL with the same WB_SRC_* values.
package mem_wb_pkg;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MEM = 2'd1;
  localparam logic [1:0] WB_SRC_PC4 = 2'd2;
  localparam logic [1:0] WB_SRC_IMM = 2'd3;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Upstream instruction, load-return and writeback-mux signals of the stage.
// master = pipeline/memory side, slave = the stage itself.
interface mem_wb_stage_if #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_alu;
  logic [WIDTH-1:0]   in_pc4;
  logic [WIDTH-1:0]   in_imm;
  logic [1:0]         in_wb_sel;
  logic [RADDR_W-1:0] in_rd;
  logic               in_reg_we;
  logic [WIDTH-1:0]   mem_rdata;
  logic               mem_rvalid;
  logic [WIDTH-1:0]   wb_a;
  logic [WIDTH-1:0]   wb_b;
  logic [WIDTH-1:0]   wb_c;
  logic [WIDTH-1:0]   wb_d;
  logic [1:0]         wb_sel;
  logic [RADDR_W-1:0] wb_rd;
  logic               wb_we;
  logic               mem_err;

  modport master (
    output in_valid, in_alu, in_pc4, in_imm, in_wb_sel, in_rd, in_reg_we,
    output mem_rdata, mem_rvalid,
    input  in_ready, wb_a, wb_b, wb_c, wb_d, wb_sel, wb_rd, wb_we, mem_err
  );

  modport slave (
    input  in_valid, in_alu, in_pc4, in_imm, in_wb_sel, in_rd, in_reg_we,
    input  mem_rdata, mem_rvalid,
    output in_ready, wb_a, wb_b, wb_c, wb_d, wb_sel, wb_rd, wb_we, mem_err
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Saturating 8-bit wait counter; expired is high in the TIMEOUT-th enabled cycle after clear.
// Zero latency on expired (combinational compare of the registered count); no backpressure.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  // count holds the number of cycles already spent, so the current one is count+1
  assign expired = (count >= 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: registers writeback candidates, holds loads until MEM_RVALID or timeout.
// Non-load write 1 cycle after accept, load k+1; in_ready low while a load is outstanding.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5,
  parameter int TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst_n,
  mem_wb_stage_if.slave bus
);

  state_t             state;
  logic [WIDTH-1:0]   wb_a_q, wb_b_q, wb_c_q, wb_d_q;
  logic [1:0]         wb_sel_q;
  logic [RADDR_W-1:0] wb_rd_q;
  logic               reg_we_q;
  logic               wb_we_q;
  logic               mem_err_q;
  logic               accept;
  logic               expired;

  assign bus.in_ready = (state != WAIT_MEM);
  assign accept       = bus.in_valid && bus.in_ready;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      ((state == WAIT_MEM) && !bus.mem_rvalid),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      wb_a_q    <= {WIDTH{1'b0}};
      wb_b_q    <= {WIDTH{1'b0}};
      wb_c_q    <= {WIDTH{1'b0}};
      wb_d_q    <= {WIDTH{1'b0}};
      wb_sel_q  <= WB_SRC_ALU;
      wb_rd_q   <= {RADDR_W{1'b0}};
      reg_we_q  <= 1'b0;
      wb_we_q   <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      wb_we_q <= 1'b0;
      case (state)
        EMPTY, WRITE: begin
          if (accept) begin
            wb_a_q   <= bus.in_alu;
            wb_c_q   <= bus.in_pc4;
            wb_d_q   <= bus.in_imm;
            wb_sel_q <= bus.in_wb_sel;
            wb_rd_q  <= bus.in_rd;
            reg_we_q <= bus.in_reg_we;
            if (bus.in_wb_sel == WB_SRC_MEM) begin
              state <= WAIT_MEM;
            end else begin
              state   <= WRITE;
              wb_we_q <= bus.in_reg_we && (bus.in_rd != {RADDR_W{1'b0}});
            end
          end else begin
            state <= EMPTY;
          end
        end
        WAIT_MEM: begin
          // Returning data wins over a coincident expiry: the load did complete
          if (bus.mem_rvalid) begin
            wb_b_q  <= bus.mem_rdata;
            wb_we_q <= reg_we_q && (wb_rd_q != {RADDR_W{1'b0}});
            state   <= WRITE;
          end else if (expired) begin
            mem_err_q <= 1'b1;
            state     <= WRITE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.wb_a    = wb_a_q;
  assign bus.wb_b    = wb_b_q;
  assign bus.wb_c    = wb_c_q;
  assign bus.wb_d    = wb_d_q;
  assign bus.wb_sel  = wb_sel_q;
  assign bus.wb_rd   = wb_rd_q;
  assign bus.wb_we   = wb_we_q;
  assign bus.mem_err = mem_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: expected register-file writes go to a scoreboard queue,
// a negedge monitor pops one per WB_WE pulse; state/latency points are checked inline.
module tb_mem_wb_stage;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.WIDTH(32), .RADDR_W(5)) bus ();

  mem_wb_stage #(.WIDTH(32), .RADDR_W(5), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm);
    bus.in_valid  = 1'b1;
    bus.in_wb_sel = sel;
    bus.in_rd     = rd;
    bus.in_reg_we = we;
    bus.in_alu    = alu;
    bus.in_pc4    = pc4;
    bus.in_imm    = imm;
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (bus.wb_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_rd", 32'(bus.wb_rd), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        logic [31:0] got;
        e = sb.pop_front();
        case (bus.wb_sel)
          2'd0:    got = bus.wb_a;
          2'd1:    got = bus.wb_b;
          2'd2:    got = bus.wb_c;
          default: got = bus.wb_d;
        endcase
        chk("wr_sel", 32'(bus.wb_sel), 32'(e.sel));
        chk("wr_rd", 32'(bus.wb_rd), 32'(e.rd));
        chk("wr_data", got, e.data);
      end
    end
  end

  initial begin
    int cnt;
    bus.in_valid   = 1'b0;
    bus.in_alu     = '0;
    bus.in_pc4     = '0;
    bus.in_imm     = '0;
    bus.in_wb_sel  = '0;
    bus.in_rd      = '0;
    bus.in_reg_we  = 1'b0;
    bus.mem_rdata  = '0;
    bus.mem_rvalid = 1'b0;

    // Reset state
    #12;
    chk("rst_wb_a", bus.wb_a, 32'h0);
    chk("rst_wb_b", bus.wb_b, 32'h0);
    chk("rst_wb_sel_rd", {25'h0, bus.wb_sel, bus.wb_rd}, 32'h0);
    chk("rst_we_err", {30'h0, bus.wb_we, bus.mem_err}, 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    rst_n = 1'b1;
    step();

    // ALU instruction
    issue(2'd0, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0);
    sb.push_back({2'd0, 5'd5, 32'h1234});
    step();
    bus.in_valid = 1'b0;
    chk("alu_wb_a", bus.wb_a, 32'h1234);
    chk("alu_wb_sel_rd", {25'h0, bus.wb_sel, bus.wb_rd}, {25'h0, 2'd0, 5'd5});
    chk("alu_we", 32'(bus.wb_we), 32'h1);
    step();
    chk("alu_we_one_cycle", 32'(bus.wb_we), 32'h0);

    // Load, stray RVALID in the accept cycle, real data 3 cycles later
    issue(2'd1, 5'd7, 1'b1, 32'h55, 32'h0, 32'h0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_1111;
    sb.push_back({2'd1, 5'd7, 32'hDEAD_BEEF});
    step();
    bus.in_valid   = 1'b0;
    bus.mem_rvalid = 1'b0;
    chk("ld_ready_c1", 32'(bus.in_ready), 32'h0);
    step();
    chk("ld_ready_c2", 32'(bus.in_ready), 32'h0);
    step();
    chk("ld_ready_c3", 32'(bus.in_ready), 32'h0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    step();
    bus.mem_rvalid = 1'b0;
    chk("ld_ready_after", 32'(bus.in_ready), 32'h1);
    chk("ld_wb_b", bus.wb_b, 32'hDEAD_BEEF);
    chk("ld_we", 32'(bus.wb_we), 32'h1);
    step();

    // Back-to-back PC4 then IMM
    issue(2'd2, 5'd1, 1'b1, 32'h0, 32'h104, 32'h0);
    sb.push_back({2'd2, 5'd1, 32'h104});
    step();
    chk("b2b_first_we_sel", {30'h0, bus.wb_sel}, 32'd2);
    chk("b2b_first_we", 32'(bus.wb_we), 32'h1);
    issue(2'd3, 5'd2, 1'b1, 32'h0, 32'h104, 32'hABCD_0000);
    sb.push_back({2'd3, 5'd2, 32'hABCD_0000});
    step();
    bus.in_valid = 1'b0;
    chk("b2b_second_sel", {30'h0, bus.wb_sel}, 32'd3);
    chk("b2b_second_we", 32'(bus.wb_we), 32'h1);

    // Suppressed writes: RD=0, then WE=0
    issue(2'd0, 5'd0, 1'b1, 32'h77, 32'h0, 32'h0);
    step();
    chk("rd0_we", 32'(bus.wb_we), 32'h0);
    chk("rd0_sel_rd", {25'h0, bus.wb_sel, bus.wb_rd}, {25'h0, 2'd0, 5'd0});
    issue(2'd2, 5'd3, 1'b0, 32'h0, 32'h200, 32'h0);
    step();
    bus.in_valid = 1'b0;
    chk("we0_we", 32'(bus.wb_we), 32'h0);
    chk("we0_sel_rd", {25'h0, bus.wb_sel, bus.wb_rd}, {25'h0, 2'd2, 5'd3});
    step();

    // Load timeout
    issue(2'd1, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0);
    step();
    bus.in_valid = 1'b0;
    cnt = 0;
    while (bus.in_ready == 1'b0 && cnt < 40) begin
      cnt++;
      step();
    end
    chk("to_wait_cycles", 32'(cnt), 32'd15);
    chk("to_we", 32'(bus.wb_we), 32'h0);
    chk("to_err", 32'(bus.mem_err), 32'h1);
    chk("to_wb_b_kept", bus.wb_b, 32'hDEAD_BEEF);
    step();
    issue(2'd0, 5'd4, 1'b1, 32'hCAFE, 32'h0, 32'h0);
    sb.push_back({2'd0, 5'd4, 32'hCAFE});
    step();
    bus.in_valid = 1'b0;
    chk("to_next_we", 32'(bus.wb_we), 32'h1);
    chk("to_err_sticky", 32'(bus.mem_err), 32'h1);
    step();

    // Reset in the middle of a load, then a late RVALID
    issue(2'd1, 5'd6, 1'b1, 32'h0, 32'h0, 32'h0);
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_ready", 32'(bus.in_ready), 32'h1);
    chk("mid_rst_err", 32'(bus.mem_err), 32'h0);
    chk("mid_rst_wb", bus.wb_a | bus.wb_b | bus.wb_c | bus.wb_d, 32'h0);
    chk("mid_rst_sel_rd_we", {24'h0, bus.wb_sel, bus.wb_rd, bus.wb_we}, 32'h0);
    step();
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    step();
    bus.mem_rvalid = 1'b0;
    chk("late_rvalid_wb_b", bus.wb_b, 32'h0);
    chk("late_rvalid_we", 32'(bus.wb_we), 32'h0);
    chk("late_rvalid_ready", 32'(bus.in_ready), 32'h1);
    step();
    step();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
